// File: rtl/jk_evo_tester.sv
// Stimulus/response harness around an evolved asynchronous JK latch.
// Applies LFSR vectors, samples the synchronized output, scores it.
module jk_evo_tester #(
  parameter int          NUM_VECTORS   = 32,
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_out,
  output logic [1:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail
);

  localparam logic [7:0] LAST      = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, SAMPLE, DONE
  } state_t;

  state_t     state;
  logic       sync1;
  logic       sync2;
  logic       golden_q;
  logic [7:0] lfsr;
  logic [7:0] idx;
  logic [7:0] cnt;

  logic [1:0] vec;
  logic       lfsr_fb;
  logic       mism;
  logic [7:0] err_next;

  // Raw 11 (toggle) is meaningless for an async latch, so it becomes hold.
  always_comb begin
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    vec      = 2'b01;
    if (idx != 8'd0)
      vec = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];
    mism     = sync2 != golden_q;
    err_next = err_count;
    if (mism && err_count != 8'hFF)
      err_next = err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      golden_q   <= 1'b0;
      lfsr       <= LFSR_SEED;
      idx        <= 8'd0;
      cnt        <= 8'd0;
      dut_in     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      first_fail <= 8'hFF;
    end else begin
      sync1 <= dut_out;
      sync2 <= sync1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count  <= 8'd0;
            first_fail <= 8'hFF;
            lfsr       <= LFSR_SEED;
            idx        <= 8'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= APPLY;
          end
        end
        APPLY: begin
          dut_in <= vec;
          if (vec == 2'b01)
            golden_q <= 1'b0;
          else if (vec == 2'b10)
            golden_q <= 1'b1;
          lfsr  <= {lfsr[6:0], lfsr_fb};
          cnt   <= SETTLE_LD;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == 8'd0)
            state <= SAMPLE;
          else
            cnt <= cnt - 8'd1;
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mism && first_fail == 8'hFF)
            first_fail <= idx;
          if (idx == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            pass   <= (err_next == 8'd0);
            dut_in <= 2'b00;
          end else begin
            idx   <= idx + 8'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
